// File: rtl/dec24_strobe.sv
// Registered one-hot decoder: y is one-hot the cycle after a handshake, held HOLD cycles, then GAP idle cycles.
// Accepts a code only in IDLE (in_ready); in_valid while busy is ignored, with no buffering.
module dec24_strobe #(
  parameter int N    = 2,
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      code,
  input  logic              en,
  output logic [(1<<N)-1:0] y,
  output logic              busy,
  output logic              done
);

  localparam int W    = 1 << N;
  localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
  // Clamped so the GAP = 0 build never elaborates a negative load value.
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [W-1:0]  ONE       = W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      y     <= '0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A transfer with en = 0 is consumed and dropped without leaving IDLE.
          if (in_valid && en) begin
            y     <= ONE << code;
            cnt   <= HOLD_LOAD;
            state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            y    <= '0;
            done <= 1'b1;
            if (GAP > 0) begin
              cnt   <= GAP_LOAD;
              state <= S_GAP;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec24_strobe.sv
// Directed bench for dec24_strobe with N=2, HOLD=3, GAP=2; expected values are hand-derived.
module tb_dec24_strobe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] code;
  logic       en;
  logic [3:0] y;
  logic       busy;
  logic       done;
  logic       run;

  int checks;
  int errors;
  int done_cnt;

  dec24_strobe #(.N(2), .HOLD(3), .GAP(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .code     (code),
    .en       (en),
    .y        (y),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    wait (run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    run      = 1'b0;
    rst      = 1'b0;
    in_valid = 1'b0;
    code     = 2'd0;
    en       = 1'b0;

    // 1. Reset with no clock running.
    #2 rst = 1'b1;
    #1;
    check("rst_y", 32'(y), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    #4 run = 1'b1;
    #3 rst = 1'b0;

    // 2. Single strobe, code 2.
    @(negedge clk);
    code = 2'd2; en = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_t0_y", 32'(y), 32'h4);
    check("single_t0_busy", 32'(busy), 32'h1);
    check("single_t0_ready", 32'(in_ready), 32'h0);
    tick();
    check("single_t1_y", 32'(y), 32'h4);
    tick();
    check("single_t2_y", 32'(y), 32'h4);
    check("single_t2_done", 32'(done), 32'h0);
    tick();
    check("single_t3_y", 32'(y), 32'h0);
    check("single_t3_done", 32'(done), 32'h1);
    check("single_t3_busy", 32'(busy), 32'h1);
    tick();
    check("single_t4_done", 32'(done), 32'h0);
    check("single_t4_ready", 32'(in_ready), 32'h0);
    tick();
    check("single_t5_ready", 32'(in_ready), 32'h1);
    check("single_t5_busy", 32'(busy), 32'h0);

    // 3. Code sweep with in_valid held high; transfers every 6 edges.
    @(negedge clk);
    code = 2'd0; en = 1'b1; in_valid = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      logic [3:0] exp_y;
      exp_y = 4'b0001 << c;
      check($sformatf("sweep%0d_y0", c), 32'(y), 32'(exp_y));
      if (c < 3) code = 2'(c + 1);
      else       in_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        tick();
        if (done) done_cnt++;
        if (k <= 2) check($sformatf("sweep%0d_hold%0d", c, k), 32'(y), 32'(exp_y));
        else        check($sformatf("sweep%0d_quiet%0d", c, k), 32'(y), 32'h0);
      end
      if (c < 3) tick();
    end
    check("sweep_done_pulses", 32'(done_cnt), 32'd4);
    check("sweep_end_ready", 32'(in_ready), 32'h1);

    // 4. Disabled decode: consumed, no strobe, no done.
    en = 1'b0; code = 2'd3; in_valid = 1'b1;
    tick();
    check("dis_y", 32'(y), 32'h0);
    check("dis_busy", 32'(busy), 32'h0);
    check("dis_done", 32'(done), 32'h0);
    check("dis_ready", 32'(in_ready), 32'h1);
    en = 1'b1; code = 2'd2;
    tick();
    in_valid = 1'b0;
    check("dis_next_y", 32'(y), 32'h4);
    check("dis_next_done", 32'(done), 32'h0);

    // 5. Async reset between edges during DRIVE.
    tick();
    check("arst_pre_y", 32'(y), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("arst_y", 32'(y), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    code = 2'd1; en = 1'b1; in_valid = 1'b1;
    tick();
    check("arst_after_y", 32'(y), 32'h2);

    // 6. in_valid with code 0 while busy is ignored.
    code = 2'd0;
    tick();
    in_valid = 1'b0;
    check("ign_t1_y", 32'(y), 32'h2);
    tick();
    check("ign_t2_y", 32'(y), 32'h2);
    tick();
    check("ign_t3_y", 32'(y), 32'h0);
    check("ign_t3_done", 32'(done), 32'h1);
    tick();
    tick();
    check("ign_t5_ready", 32'(in_ready), 32'h1);
    tick();
    check("ign_t6_y", 32'(y), 32'h0);
    check("ign_t6_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
